// File: rtl/common_pkg.sv
// Shared register-file types: register ids, widths and write-back port encoding.
package common_pkg;

    localparam int unsigned REG_NUM = 16;
    localparam int unsigned DATA_W  = 16;

    typedef enum logic [3:0] {
        R_ZR  = 4'd0,
        R_R1  = 4'd1,
        R_R2  = 4'd2,
        R_R3  = 4'd3,
        R_R4  = 4'd4,
        R_R5  = 4'd5,
        R_R6  = 4'd6,
        R_R7  = 4'd7,
        R_R8  = 4'd8,
        R_R9  = 4'd9,
        R_R10 = 4'd10,
        R_R11 = 4'd11,
        R_R12 = 4'd12,
        R_R13 = 4'd13,
        R_R14 = 4'd14,
        R_MEM = 4'd15
    } reg_id_e;

    typedef enum logic {
        PORT_ALU = 1'b0,
        PORT_LD  = 1'b1
    } wb_port_e;

    // Zero register and memory alias are never written and never tracked.
    function automatic logic is_real_reg(reg_id_e r);
        return (r != R_ZR) && (r != R_MEM);
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue, cleared on committed write.
module wb_scoreboard
    import common_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               issue_i,
    input  reg_id_e            issue_dest_i,
    input  logic               clr_i,
    input  reg_id_e            clr_dest_i,
    input  logic               ret_i,
    input  reg_id_e            ret_dest_i,
    input  reg_id_e            s1_i,
    input  reg_id_e            s2_i,
    input  reg_id_e            ab_i,
    input  reg_id_e            alu_dest_i,
    output logic               hazard_o,
    output logic               alu_blocked_o,
    output logic [REG_NUM-1:0] pending_o,
    output logic               err_o
);

    logic [REG_NUM-1:0] pend_d, pend_q;
    logic [REG_NUM-1:0] clr_mask, set_mask;
    logic               err_d, err_q;

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        err_d    = 1'b0;
        if (clr_i) begin
            clr_mask[clr_dest_i] = 1'b1;
        end
        // A register being cleared on this edge may be re-issued without error.
        if (issue_i && is_real_reg(issue_dest_i)) begin
            if (pend_q[issue_dest_i] && !clr_mask[issue_dest_i]) begin
                err_d = 1'b1;
            end else begin
                set_mask[issue_dest_i] = 1'b1;
            end
        end
        if (ret_i && is_real_reg(ret_dest_i) && !pend_q[ret_dest_i]) begin
            err_d = 1'b1;
        end
        pend_d = (pend_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign hazard_o      = pend_q[s1_i] | pend_q[s2_i] | pend_q[ab_i];
    assign alu_blocked_o = pend_q[alu_dest_i];
    assign pending_o     = pend_q;
    assign err_o         = err_q;

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin share of the register-file write port between ALU and loads.
module regfile_wb_sched
    import common_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_alu_valid,
    input  reg_id_e           i_alu_dest,
    input  logic [DATA_W-1:0] i_alu_data,
    output logic              o_alu_ready,
    input  logic              i_ld_issue,
    input  reg_id_e           i_ld_issue_dest,
    input  logic              i_ld_valid,
    input  reg_id_e           i_ld_dest,
    input  logic [DATA_W-1:0] i_ld_data,
    output logic              o_ld_ready,
    input  reg_id_e           i_s1_addr,
    input  reg_id_e           i_s2_addr,
    input  reg_id_e           i_ab_addr,
    output logic              o_hazard,
    output logic              o_wr_en,
    output reg_id_e           o_dest_addr,
    output logic [DATA_W-1:0] o_dest_data,
    output logic [REG_NUM-1:0] o_pending,
    output logic              o_sb_err
);

    wb_port_e          last_d, last_q;
    logic              wr_en_d, wr_en_q;
    reg_id_e           dest_addr_d, dest_addr_q;
    logic [DATA_W-1:0] dest_data_d, dest_data_q;
    logic              alu_blocked, alu_elig;
    logic              alu_gnt, ld_gnt;

    wb_scoreboard u_scoreboard (
        .clk_i         (i_clk),
        .rst_i         (i_rst),
        .issue_i       (i_ld_issue),
        .issue_dest_i  (i_ld_issue_dest),
        .clr_i         (wr_en_q),
        .clr_dest_i    (dest_addr_q),
        .ret_i         (ld_gnt),
        .ret_dest_i    (i_ld_dest),
        .s1_i          (i_s1_addr),
        .s2_i          (i_s2_addr),
        .ab_i          (i_ab_addr),
        .alu_dest_i    (i_alu_dest),
        .hazard_o      (o_hazard),
        .alu_blocked_o (alu_blocked),
        .pending_o     (o_pending),
        .err_o         (o_sb_err)
    );

    // WAW guard: an ALU write must not land before an older load to the same register.
    assign alu_elig = i_alu_valid & ~alu_blocked;

    always_comb begin
        alu_gnt = 1'b0;
        ld_gnt  = 1'b0;
        if (i_ld_valid && alu_elig) begin
            if (last_q == PORT_ALU) begin
                ld_gnt = 1'b1;
            end else begin
                alu_gnt = 1'b1;
            end
        end else begin
            ld_gnt  = i_ld_valid;
            alu_gnt = alu_elig;
        end
    end

    always_comb begin
        last_d      = last_q;
        wr_en_d     = 1'b0;
        dest_addr_d = dest_addr_q;
        dest_data_d = dest_data_q;
        if (ld_gnt) begin
            last_d      = PORT_LD;
            wr_en_d     = is_real_reg(i_ld_dest);
            dest_addr_d = i_ld_dest;
            dest_data_d = i_ld_data;
        end else if (alu_gnt) begin
            last_d      = PORT_ALU;
            wr_en_d     = is_real_reg(i_alu_dest);
            dest_addr_d = i_alu_dest;
            dest_data_d = i_alu_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_q      <= PORT_ALU;
            wr_en_q     <= 1'b0;
            dest_addr_q <= R_ZR;
            dest_data_q <= '0;
        end else begin
            last_q      <= last_d;
            wr_en_q     <= wr_en_d;
            dest_addr_q <= dest_addr_d;
            dest_data_q <= dest_data_d;
        end
    end

    assign o_alu_ready = alu_gnt;
    assign o_ld_ready  = ld_gnt;
    assign o_wr_en     = wr_en_q;
    assign o_dest_addr = dest_addr_q;
    assign o_dest_data = dest_data_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed stimulus, expected writes queued and checked by a monitor.
module tb_regfile_wb_sched;
    import common_pkg::*;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    reg_id_e     alu_dest;
    logic [15:0] alu_data;
    logic        alu_ready;
    logic        ld_issue;
    reg_id_e     ld_issue_dest;
    logic        ld_valid;
    reg_id_e     ld_dest;
    logic [15:0] ld_data;
    logic        ld_ready;
    reg_id_e     s1, s2, ab;
    logic        hazard;
    logic        wr_en;
    reg_id_e     dest_addr;
    logic [15:0] dest_data;
    logic [15:0] pending;
    logic        sb_err;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_pass   = 0;

    regfile_wb_sched dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_alu_valid     (alu_valid),
        .i_alu_dest      (alu_dest),
        .i_alu_data      (alu_data),
        .o_alu_ready     (alu_ready),
        .i_ld_issue      (ld_issue),
        .i_ld_issue_dest (ld_issue_dest),
        .i_ld_valid      (ld_valid),
        .i_ld_dest       (ld_dest),
        .i_ld_data       (ld_data),
        .o_ld_ready      (ld_ready),
        .i_s1_addr       (s1),
        .i_s2_addr       (s2),
        .i_ab_addr       (ab),
        .o_hazard        (hazard),
        .o_wr_en         (wr_en),
        .o_dest_addr     (dest_addr),
        .o_dest_data     (dest_data),
        .o_pending       (pending),
        .o_sb_err        (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [15:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Every committed write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(dest_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 32'(dest_addr), 32'(mon_e.addr));
                chk("wr_data", 32'(dest_data), 32'(mon_e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] ld_pat;
        ld_pat = 4'b0101;
        rst = 1'b1;
        alu_valid = 1'b0; alu_dest = R_ZR; alu_data = '0;
        ld_issue = 1'b0; ld_issue_dest = R_ZR;
        ld_valid = 1'b0; ld_dest = R_ZR; ld_data = '0;
        s1 = R_ZR; s2 = R_ZR; ab = R_ZR;

        // Reset values
        repeat (2) @(posedge clk);
        smp();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_addr", 32'(dest_addr), 32'd0);
        chk("rst_data", 32'(dest_data), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_hazard", 32'(hazard), 32'd0);
        chk("rst_sb_err", 32'(sb_err), 32'd0);
        tick();
        rst = 1'b0;

        // Load lifecycle on reg 3
        ld_issue = 1'b1; ld_issue_dest = R_R3;
        tick();
        ld_issue = 1'b0; s1 = R_R3;
        smp();
        chk("lc_pending", 32'(pending), 32'h0008);
        chk("lc_hazard_set", 32'(hazard), 32'd1);
        tick();
        ld_valid = 1'b1; ld_dest = R_R3; ld_data = 16'hBEEF;
        smp();
        chk("lc_ld_ready", 32'(ld_ready), 32'd1);
        push(4'd3, 16'hBEEF);
        tick();
        ld_valid = 1'b0;
        smp();
        chk("lc_wr_en", 32'(wr_en), 32'd1);
        chk("lc_hazard_n1", 32'(hazard), 32'd1);
        tick();
        smp();
        chk("lc_hazard_n2", 32'(hazard), 32'd0);
        chk("lc_pending_clr", 32'(pending), 32'd0);
        chk("lc_sb_err", 32'(sb_err), 32'd0);
        s1 = R_ZR;

        // Contention from a fresh arbiter: load, ALU, load, ALU
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        alu_valid = 1'b1; alu_dest = R_R1; alu_data = 16'h0011;
        ld_valid  = 1'b1; ld_dest  = R_R2; ld_data  = 16'h0022;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("ct_ld_ready", 32'(ld_ready), 32'(ld_pat[k]));
            chk("ct_alu_ready", 32'(alu_ready), 32'(!ld_pat[k]));
            // reg 2 was never issued, so each load grant flags an error one cycle later
            chk("ct_sb_err", 32'(sb_err), 32'(k % 2));
            if (ld_pat[k]) push(4'd2, 16'h0022);
            else push(4'd1, 16'h0011);
            tick();
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        smp();
        chk("ct_sb_err_end", 32'(sb_err), 32'd0);

        // WAW guard on reg 5
        tick();
        ld_issue = 1'b1; ld_issue_dest = R_R5;
        tick();
        ld_issue = 1'b0;
        alu_valid = 1'b1; alu_dest = R_R5; alu_data = 16'h5A5A;
        smp();
        chk("waw_pending", 32'(pending), 32'h0020);
        chk("waw_alu_blk0", 32'(alu_ready), 32'd0);
        tick();
        smp();
        chk("waw_alu_blk1", 32'(alu_ready), 32'd0);
        tick();
        ld_valid = 1'b1; ld_dest = R_R5; ld_data = 16'h1234;
        smp();
        chk("waw_ld_ready", 32'(ld_ready), 32'd1);
        chk("waw_alu_blk2", 32'(alu_ready), 32'd0);
        push(4'd5, 16'h1234);
        tick();
        ld_valid = 1'b0;
        smp();
        chk("waw_alu_blk3", 32'(alu_ready), 32'd0);
        tick();
        smp();
        chk("waw_alu_gnt", 32'(alu_ready), 32'd1);
        push(4'd5, 16'h5A5A);
        tick();
        alu_valid = 1'b0;
        smp();
        chk("waw_pending_clr", 32'(pending), 32'd0);

        // Double issue to reg 4
        tick();
        ld_issue = 1'b1; ld_issue_dest = R_R4;
        tick();
        tick();
        ld_issue = 1'b0;
        smp();
        chk("dbl_sb_err", 32'(sb_err), 32'd1);
        chk("dbl_pending", 32'(pending), 32'h0010);
        tick();
        smp();
        chk("dbl_sb_err_once", 32'(sb_err), 32'd0);
        chk("dbl_pending_hold", 32'(pending), 32'h0010);

        // Clear and re-issue of reg 4 on the same edge
        tick();
        ld_valid = 1'b1; ld_dest = R_R4; ld_data = 16'h4444;
        smp();
        chk("same_ld_ready", 32'(ld_ready), 32'd1);
        push(4'd4, 16'h4444);
        tick();
        ld_valid = 1'b0;
        ld_issue = 1'b1; ld_issue_dest = R_R4;
        smp();
        chk("same_wr_en", 32'(wr_en), 32'd1);
        tick();
        ld_issue = 1'b0;
        smp();
        chk("same_pending", 32'(pending), 32'h0010);
        chk("same_sb_err", 32'(sb_err), 32'd0);
        tick();
        ld_valid = 1'b1; ld_dest = R_R4; ld_data = 16'h4445;
        smp();
        chk("same_ld_ready2", 32'(ld_ready), 32'd1);
        push(4'd4, 16'h4445);
        tick();
        ld_valid = 1'b0;
        tick();
        smp();
        chk("same_pending_clr", 32'(pending), 32'd0);

        // Return to non-pending reg 6
        tick();
        ld_valid = 1'b1; ld_dest = R_R6; ld_data = 16'h6666;
        smp();
        chk("np_ld_ready", 32'(ld_ready), 32'd1);
        push(4'd6, 16'h6666);
        tick();
        ld_valid = 1'b0;
        smp();
        chk("np_sb_err", 32'(sb_err), 32'd1);

        // Issue to the zero register is ignored silently
        tick();
        ld_issue = 1'b1; ld_issue_dest = R_ZR;
        tick();
        ld_issue = 1'b0;
        smp();
        chk("zr_pending", 32'(pending), 32'd0);
        chk("zr_sb_err", 32'(sb_err), 32'd0);

        // Discarded ALU write to R_ZR
        tick();
        alu_valid = 1'b1; alu_dest = R_ZR; alu_data = 16'hDEAD;
        smp();
        chk("disc_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        alu_valid = 1'b0;
        smp();
        chk("disc_wr_en", 32'(wr_en), 32'd0);

        // Reset in the middle of a staged write with a load outstanding
        tick();
        ld_issue = 1'b1; ld_issue_dest = R_R9;
        alu_valid = 1'b1; alu_dest = R_R7; alu_data = 16'h7777;
        smp();
        chk("mid_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        ld_issue = 1'b0; alu_valid = 1'b0;
        chk("mid_wr_staged", 32'(wr_en), 32'd1);
        chk("mid_pending", 32'(pending), 32'h0200);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_addr", 32'(dest_addr), 32'd0);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        smp();
        tick();
        rst = 1'b0;
        ld_valid = 1'b1; ld_dest = R_R9; ld_data = 16'h9999;
        smp();
        chk("mid_ld_ready", 32'(ld_ready), 32'd1);
        push(4'd9, 16'h9999);
        tick();
        ld_valid = 1'b0;
        smp();
        chk("mid_sb_err", 32'(sb_err), 32'd1);

        tick();
        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler for the 16-entry register file: shares its single write port between the ALU result path and the memory-load return path, and keeps a per-register pending scoreboard for in-flight loads. The scheduler drives the register file write port (`wr_en`, `dest_addr`, `dest_data`). It exposes a hazard flag that the decode/issue sequencer uses to stall reads of registers whose load has not yet been written.

## Interface
Parameters:
- none. Width is 16 bits and register ids are `reg_id_e`, both fixed by `common_pkg`.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_alu_valid`  in  1  ALU write request.
- `i_alu_dest`  in  reg_id_e  ALU destination.
- `i_alu_data`  in  16  ALU result.
- `o_alu_ready`  out  1  ALU request accepted this cycle.
- `i_ld_issue`  in  1  load issued; mark destination pending.
- `i_ld_issue_dest`  in  reg_id_e  destination of the issued load.
- `i_ld_valid`  in  1  load data returning.
- `i_ld_dest`  in  reg_id_e  destination of the returning load.
- `i_ld_data`  in  16  load data.
- `o_ld_ready`  out  1  load return accepted this cycle.
- `i_s1_addr`, `i_s2_addr`, `i_ab_addr`  in  reg_id_e  source ids of the instruction being issued.
- `o_hazard`  out  1  any of the three sources is pending.
- `o_wr_en`  out  1  register file write enable (registered).
- `o_dest_addr`  out  reg_id_e  register file write address (registered).
- `o_dest_data`  out  16  register file write data (registered).
- `o_pending`  out  16  scoreboard bits, bit n = reg id n.
- `o_sb_err`  out  1  one-cycle pulse on a scoreboard protocol violation (registered).

## Operation
- **Scoreboard** `pend[15:0]`.
  - Set on `i_ld_issue` for `i_ld_issue_dest`.
  - Cleared at the edge where the committed write to that register occurs: `o_wr_en=1` with that `o_dest_addr`.
  - Issue to `R_ZR` or `R_MEM`: no effect, no error.
- **Issue to an already-pending register** that is not being cleared this cycle:
  - The issue is ignored.
  - `o_sb_err` pulses.
  - If the clear and the issue hit the same register on the same edge, the set wins, with no error.
- **Hazard:** `o_hazard = pend[s1] | pend[s2] | pend[ab]`. Combinational from `pend`, no bypass.
- **Arbitration:** one grant per cycle, round-robin via a 1-bit `last` flag. With both eligible, the port not granted last time wins; `last` resets to ALU, so the first contested grant goes to load.
- **ALU eligibility (WAW guard):**
  - Eligible only if `pend[i_alu_dest]==0`.
  - An ALU request to a pending register waits with `o_alu_ready=0` until that bit clears.
  - Load is always eligible.
- **Ready behaviour:**
  - `o_alu_ready` and `o_ld_ready` are combinational grants, at most one high per cycle.
  - A requester must hold valid, dest and data until it sees ready.
- **Return without a pending bit:** a load return whose dest bit is not pending is still written, and `o_sb_err` pulses.
- **Discarded writes:** a granted write to `R_ZR` or `R_MEM` is acknowledged but yields `o_wr_en=0`.

## Timing
- Reset values:
  - `o_wr_en=0`, `o_dest_addr=R_ZR`, `o_dest_data=16'h0000`.
  - `pend=0`, `o_sb_err=0`, `last`=ALU.
  - `o_hazard=0` follows from `pend=0`.
- Grant in cycle N gives `o_wr_en/addr/data` valid in cycle N+1.
  - The register file writes at the end of N+1; `pend` clears at the same edge.
  - `o_hazard` is still high during N+1 and low in N+2.
- Issue sampled at the end of cycle N sets `pend` in N+1. `o_hazard` can rise in N+1.
- Reset asserted mid-operation clears the scoreboard and any staged write. Outstanding loads returning afterwards are written and flag `o_sb_err`.

## Structure
- Put `reg_id_e` and a new `REG_NUM=16` localparam in `common_pkg`.
- Sub-module `wb_scoreboard`: pend register, set/clear/error logic, three-port hazard lookup.
- The arbiter and output register stay in the top module.

## Test plan
- **Reset:** assert `i_rst` mid-write → `o_wr_en=0`, `o_dest_addr=R_ZR`, `o_pending=16'h0000` immediately.
- **Load lifecycle:**
  - Issue a load to reg 3 → `o_pending=16'h0008`.
  - Sources s1=3 → `o_hazard=1`.
  - Return data 16'hBEEF → `o_wr_en=1` with addr 3 one cycle later; `o_hazard=0` two cycles after the grant.
- **Contention:** ALU (reg 1, 16'h0011) and load (reg 2, 16'h0022) both valid for 4 cycles → grants alternate load, ALU, load, ALU.
- **WAW guard:**
  - Reg 5 pending; ALU requests reg 5 → `o_alu_ready=0`.
  - After the load writes reg 5, the ALU is granted the next cycle and its value is written last.
- **Errors:**
  - Double issue to reg 4 → `o_sb_err` pulses once and `pend[4]` stays 1.
  - Load return to non-pending reg 6 → written and `o_sb_err` pulses.
  - Issue and clear of reg 4 on the same edge → `pend[4]=1`, no error.
- **Discard:** ALU write to `R_ZR` → `o_alu_ready=1`, `o_wr_en` stays 0.
